ir_byte_assembler: RTL

IR_BYTE_ASSEMBLER -- requirements
Module: ir_byte_assembler

---
 rtl/ir_pkg.sv | 22 ++
 rtl/ir_fill_ctrl.sv | 66 ++++++
 rtl/ir_byte_assembler.sv | 80 ++++++++
 3 files changed

// File: rtl/ir_pkg.sv
// Shared encodings for the byte assembler: FunSel operations, fill FSM states
// and the lane-index width helper.
package ir_pkg;

    typedef enum logic [1:0] {
        FS_CLR  = 2'b00,
        FS_LOAD = 2'b01,
        FS_INC  = 2'b10,
        FS_DEC  = 2'b11
    } funsel_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_FILL = 2'b01,
        ST_DONE = 2'b10
    } fill_state_e;

    function automatic int lane_w(input int bytes);
        return (bytes > 1) ? $clog2(bytes) : 1;
    endfunction

endpackage

// File: rtl/ir_fill_ctrl.sv
// Fill sequencer: walks the lane pointer from 0 to BYTES-1, one lane per
// accepted byte, then pulses done for a single cycle before returning to idle.
module ir_fill_ctrl
    import ir_pkg::*;
#(
    parameter int BYTES = 2,
    parameter int LW    = lane_w(BYTES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_fill_start,
    input  logic          i_in_valid,
    output logic          o_we,
    output logic [LW-1:0] o_ptr,
    output logic          o_idle,
    output logic          o_busy,
    output logic          o_in_ready,
    output logic          o_fill_done
);

    fill_state_e   r_state;
    fill_state_e   w_state_nxt;
    logic [LW-1:0] r_ptr;
    logic [LW-1:0] w_ptr_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            ST_IDLE: begin
                if (i_fill_start) begin
                    w_state_nxt = ST_FILL;
                    w_ptr_nxt   = '0;
                end
            end
            ST_FILL: begin
                if (i_in_valid) begin
                    w_ptr_nxt = r_ptr + LW'(1);
                    if (r_ptr == LW'(BYTES - 1)) begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    assign o_we        = (r_state == ST_FILL) && i_in_valid;
    assign o_ptr       = r_ptr;
    assign o_idle      = (r_state == ST_IDLE);
    assign o_busy      = (r_state == ST_FILL);
    assign o_in_ready  = (r_state == ST_FILL);
    assign o_fill_done = (r_state == ST_DONE);

endmodule

// File: rtl/ir_byte_assembler.sv
// Multi-lane byte register with clear/load/increment/decrement operations and
// a handshaked sequential fill that writes lanes 0..BYTES-1 in order.
module ir_byte_assembler
    import ir_pkg::*;
#(
    parameter  int BYTES = 2,
    localparam int LW    = lane_w(BYTES)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         I,
    input  logic [1:0]         FunSel,
    input  logic [LW-1:0]      lane,
    input  logic               enable,
    input  logic               fill_start,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               busy,
    output logic               fill_done,
    output logic [8*BYTES-1:0] data_out
);

    localparam int            DW  = 8 * BYTES;
    localparam logic [DW-1:0] ONE = DW'(1);

    logic [DW-1:0] r_data;
    logic [DW-1:0] w_data_nxt;
    logic          w_we;
    logic          w_idle;
    logic [LW-1:0] w_ptr;

    ir_fill_ctrl #(
        .BYTES (BYTES),
        .LW    (LW)
    ) u_fill_ctrl (
        .clk          (clk),
        .rst          (rst),
        .i_fill_start (fill_start),
        .i_in_valid   (in_valid),
        .o_we         (w_we),
        .o_ptr        (w_ptr),
        .o_idle       (w_idle),
        .o_busy       (busy),
        .o_in_ready   (in_ready),
        .o_fill_done  (fill_done)
    );

    // Fill writes only happen in FILL; FunSel only in IDLE and only when no fill is starting.
    always_comb begin
        w_data_nxt = r_data;
        if (w_we) begin
            for (int k = 0; k < BYTES; k++) begin
                if (w_ptr == LW'(k)) w_data_nxt[8*k +: 8] = I;
            end
        end else if (w_idle && !fill_start && enable) begin
            case (funsel_e'(FunSel))
                FS_CLR:  w_data_nxt = '0;
                FS_LOAD: begin
                    for (int k = 0; k < BYTES; k++) begin
                        if (lane == LW'(k)) w_data_nxt[8*k +: 8] = I;
                    end
                end
                FS_INC:  w_data_nxt = r_data + ONE;
                FS_DEC:  w_data_nxt = r_data - ONE;
                default: w_data_nxt = r_data;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
        end else begin
            r_data <= w_data_nxt;
        end
    end

    assign data_out = r_data;

endmodule
